// File: rtl/dlx_memory_access_stage.sv
// DLX MEM-stage load/store unit: big-endian lane alignment, sign/zero extension,
// misalignment rejection and ack timeout toward a req/ack data RAM.
module dlx_memory_access_stage #(
    parameter int unsigned N           = 32,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  logic         is_load,
    input  logic         is_store,
    input  logic [1:0]   size,
    input  logic         is_signed,
    input  logic [N-1:0] alu_result,
    input  logic [N-1:0] store_data,
    output logic         dram_req,
    output logic         dram_we,
    output logic [N-1:0] dram_addr,
    output logic [3:0]   dram_be,
    output logic [N-1:0] dram_wdata,
    input  logic         dram_ack,
    input  logic [N-1:0] dram_rdata,
    output logic [N-1:0] data_from_memory,
    output logic [N-1:0] data_from_alu,
    output logic         select_wb,
    output logic         wb_valid,
    output logic         stall,
    output logic         misaligned,
    output logic         bus_error
);
    localparam int unsigned BW = 4;
    localparam int unsigned CW = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_we;
    logic [N-1:0]  r_addr;
    logic [BW-1:0] r_be;
    logic [N-1:0]  r_wdata;
    logic [1:0]    r_off;
    logic          r_byte;
    logic          r_half;
    logic          r_signed;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_dfm;
    logic [N-1:0]  r_dfa;
    logic          r_sel;
    logic          r_wb_valid;
    logic          r_misaligned;
    logic          r_bus_error;

    logic          w_is_mem;
    logic          w_is_half;
    logic          w_is_word;
    logic          w_misaligned;
    logic          w_accept;
    logic          w_busy;
    logic          w_timeout;
    logic [1:0]    w_off;
    logic [BW-1:0] w_be;
    logic [N-1:0]  w_wdata;
    logic [N-1:0]  w_shifted;
    logic [N-1:0]  w_load;

    assign w_off        = alu_result[1:0];
    assign w_is_mem     = valid_in & (is_load | is_store);
    assign w_is_word    = size[1];
    assign w_is_half    = (size == 2'b01);
    assign w_misaligned = w_is_mem & ((w_is_half & w_off[0]) | (w_is_word & (|w_off)));
    assign w_busy       = (r_state == S_BUSY);
    assign w_accept     = (r_state == S_IDLE) & w_is_mem & ~w_misaligned;

    // Byte enables and lane-replicated store data for the incoming op
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = store_data;
        if (!w_is_word) begin
            if (w_is_half) begin
                w_be    = w_off[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{store_data[15:0]}};
            end else begin
                w_be    = 4'b1000 >> w_off;
                w_wdata = {4{store_data[7:0]}};
            end
        end
    end

    // Shift the addressed lane to the top of the word, then extend
    assign w_shifted = dram_rdata << {r_off, 3'b000};

    always_comb begin
        w_load = w_shifted;
        if (r_half) begin
            w_load = {{(N-16){r_signed & w_shifted[N-1]}}, w_shifted[N-1 -: 16]};
        end else if (r_byte) begin
            w_load = {{(N-8){r_signed & w_shifted[N-1]}}, w_shifted[N-1 -: 8]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (dram_ack) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, timeout counter and write-back registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_off        <= '0;
            r_byte       <= 1'b0;
            r_half       <= 1'b0;
            r_signed     <= 1'b0;
            r_cnt        <= '0;
            r_dfm        <= '0;
            r_dfa        <= '0;
            r_sel        <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_wb_valid   <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            if (r_state == S_IDLE) begin
                if (valid_in && !is_load && !is_store) begin
                    r_dfa      <= alu_result;
                    r_sel      <= 1'b1;
                    r_wb_valid <= 1'b1;
                end else if (w_misaligned) begin
                    r_misaligned <= 1'b1;
                end else if (w_accept) begin
                    r_we     <= is_store;
                    r_addr   <= {alu_result[N-1:2], 2'b00};
                    r_be     <= w_be;
                    r_wdata  <= w_wdata;
                    r_off    <= w_off;
                    r_byte   <= ~w_is_word & ~w_is_half;
                    r_half   <= w_is_half;
                    r_signed <= is_signed;
                    r_cnt    <= '0;
                end
            end else begin
                if (dram_ack) begin
                    r_cnt <= '0;
                    if (!r_we) begin
                        r_dfm      <= w_load;
                        r_sel      <= 1'b0;
                        r_wb_valid <= 1'b1;
                    end
                end else if (w_timeout) begin
                    r_cnt       <= '0;
                    r_bus_error <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign dram_req         = w_busy;
    assign dram_we          = r_we;
    assign dram_addr        = r_addr;
    assign dram_be          = r_be;
    assign dram_wdata       = r_wdata;
    assign data_from_memory = r_dfm;
    assign data_from_alu    = r_dfa;
    assign select_wb        = r_sel;
    assign wb_valid         = r_wb_valid;
    assign misaligned       = r_misaligned;
    assign bus_error        = r_bus_error;
    assign stall            = ~rst & (w_accept | (w_busy & ~dram_ack));

endmodule

// File: tb/tb_dlx_memory_access_stage.sv
// Bench for dlx_memory_access_stage: hand-written vectors, randomized ops against a
// lane-level reference model, and timeout / reset / stray-ack sequences.
module tb_dlx_memory_access_stage;
    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, is_load, is_store, is_signed;
    logic [1:0]  size;
    logic [31:0] alu_result, store_data;
    logic        dram_req, dram_we, dram_ack;
    logic [31:0] dram_addr, dram_wdata, dram_rdata;
    logic [3:0]  dram_be;
    logic [31:0] data_from_memory, data_from_alu;
    logic        select_wb, wb_valid, stall, misaligned, bus_error;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_alu, last_dfm;

    always #5 clk = ~clk;

    dlx_memory_access_stage #(.N(32), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .is_load(is_load), .is_store(is_store),
        .size(size), .is_signed(is_signed), .alu_result(alu_result), .store_data(store_data),
        .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr), .dram_be(dram_be),
        .dram_wdata(dram_wdata), .dram_ack(dram_ack), .dram_rdata(dram_rdata),
        .data_from_memory(data_from_memory), .data_from_alu(data_from_alu),
        .select_wb(select_wb), .wb_valid(wb_valid), .stall(stall),
        .misaligned(misaligned), .bus_error(bus_error)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rd;
        int          dly;
        logic        e_mis;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_val;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic ld, input logic st, input logic [1:0] sz,
                                 input logic sgn, input logic [31:0] addr, input logic [31:0] sd,
                                 input logic [31:0] rd, input int dly, input logic mis,
                                 input logic [3:0] be, input logic [31:0] wd, input logic [31:0] val);
        vec_t v;
        v.ld = ld; v.st = st; v.sz = sz; v.sgn = sgn; v.addr = addr; v.sd = sd; v.rd = rd;
        v.dly = dly; v.e_mis = mis; v.e_be = be; v.e_wdata = wd; v.e_val = val;
        return v;
    endfunction

    // Reference: treat the word as four big-endian byte lanes and reason per byte
    function automatic vec_t model(input vec_t vin);
        vec_t        v;
        int          nb, o;
        longint      val;
        logic [3:0]  be;
        logic [31:0] wd;
        v  = vin;
        o  = int'(v.addr[1:0]);
        nb = (v.sz == 2'd0) ? 1 : (v.sz == 2'd1) ? 2 : 4;
        v.e_mis = (v.ld || v.st) && ((o % nb) != 0);
        be = '0;
        wd = '0;
        for (int k = 0; k < 4; k++) begin
            if (k >= o && k < o + nb) be[3-k] = 1'b1;
            wd[31-8*k -: 8] = v.sd[8*(nb-1-(k % nb)) +: 8];
        end
        v.e_be    = be;
        v.e_wdata = wd;
        if (!v.ld && !v.st) begin
            v.e_val = v.addr;
        end else if (!v.e_mis) begin
            val = 0;
            for (int i = 0; i < nb; i++) val = val * 256 + longint'(v.rd[31-8*(o+i) -: 8]);
            if (v.sgn && nb < 4 && val >= (longint'(1) << (8*nb-1))) val = val - (longint'(1) << (8*nb));
            v.e_val = 32'(val);
        end else begin
            v.e_val = '0;
        end
        return v;
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req"}, 32'(dram_req), 32'd0);
        chk({tag, "_we"}, 32'(dram_we), 32'd0);
        chk({tag, "_addr"}, dram_addr, 32'd0);
        chk({tag, "_be"}, 32'(dram_be), 32'd0);
        chk({tag, "_wdata"}, dram_wdata, 32'd0);
        chk({tag, "_dfm"}, data_from_memory, 32'd0);
        chk({tag, "_dfa"}, data_from_alu, 32'd0);
        chk({tag, "_sel"}, 32'(select_wb), 32'd0);
        chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_mis"}, 32'(misaligned), 32'd0);
        chk({tag, "_berr"}, 32'(bus_error), 32'd0);
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
        alu_result = $urandom; store_data = $urandom;
    endtask

    // Called while clk is low; returns while clk is low in the cycle after completion
    task automatic apply(input vec_t v);
        bit nonmem, is_ld;
        int stalls;
        nonmem = !v.ld && !v.st;
        is_ld  = v.ld && !v.st;
        valid_in = 1'b1; is_load = v.ld; is_store = v.st; size = v.sz;
        is_signed = v.sgn; alu_result = v.addr; store_data = v.sd;
        #1;
        chk("stall_accept", 32'(stall), 32'(!nonmem && !v.e_mis));
        @(negedge clk);
        idle_inputs();
        if (nonmem || v.e_mis) begin
            #1;
            if (nonmem) begin
                chk("alu_wbv", 32'(wb_valid), 32'd1);
                chk("alu_sel", 32'(select_wb), 32'd1);
                chk("alu_data", data_from_alu, v.e_val);
                last_alu = v.e_val;
            end else begin
                chk("mis_pulse", 32'(misaligned), 32'd1);
                chk("mis_wbv", 32'(wb_valid), 32'd0);
                chk("mis_req", 32'(dram_req), 32'd0);
                chk("mis_stall", 32'(stall), 32'd0);
                chk("mis_dfa_hold", data_from_alu, last_alu);
            end
            @(negedge clk);
            #1;
            chk("pulse_wbv_fall", 32'(wb_valid), 32'd0);
            chk("pulse_mis_fall", 32'(misaligned), 32'd0);
            return;
        end
        stalls = 1;
        for (int c = 1; c <= v.dly; c++) begin
            if (c == v.dly) begin
                dram_ack = 1'b1;
                dram_rdata = v.rd;
            end
            #1;
            chk("busy_req", 32'(dram_req), 32'd1);
            chk("busy_we", 32'(dram_we), 32'(v.st));
            chk("busy_addr", dram_addr, {v.addr[31:2], 2'b00});
            chk("busy_be", 32'(dram_be), 32'(v.e_be));
            if (v.st) chk("busy_wdata", dram_wdata, v.e_wdata);
            if (stall) stalls++;
            @(negedge clk);
        end
        dram_ack = 1'b0;
        dram_rdata = $urandom;
        #1;
        chk("done_req", 32'(dram_req), 32'd0);
        chk("done_wbv", 32'(wb_valid), 32'(is_ld));
        chk("stall_cycles", 32'(stalls), 32'(v.dly));
        chk("done_dfa_hold", data_from_alu, last_alu);
        if (is_ld) begin
            chk("load_data", data_from_memory, v.e_val);
            chk("load_sel", 32'(select_wb), 32'd0);
            last_dfm = v.e_val;
        end else begin
            chk("store_dfm_hold", data_from_memory, last_dfm);
        end
    endtask

    vec_t tbl[13];
    vec_t rv;
    int   n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ld st sz sgn addr sd rd dly | mis be wdata value
        tbl[0]  = mkv(0, 0, 2'd2, 0, 32'hDEADBEEF, 32'h0, 32'h0, 1, 0, 4'b0000, 32'h0, 32'hDEADBEEF);
        tbl[1]  = mkv(1, 0, 2'd0, 1, 32'h00000101, 32'h0, 32'h12803456, 3, 0, 4'b0100, 32'h0, 32'hFFFFFF80);
        tbl[2]  = mkv(1, 0, 2'd0, 0, 32'h00000101, 32'h0, 32'h12803456, 3, 0, 4'b0100, 32'h0, 32'h00000080);
        tbl[3]  = mkv(0, 1, 2'd1, 0, 32'h00000202, 32'h0000ABCD, 32'h0, 2, 0, 4'b0011, 32'hABCDABCD, 32'h0);
        tbl[4]  = mkv(1, 0, 2'd2, 0, 32'h00000006, 32'h0, 32'h0, 1, 1, 4'b0000, 32'h0, 32'h0);
        tbl[5]  = mkv(1, 0, 2'd1, 1, 32'h00000200, 32'h0, 32'h80017FFF, 1, 0, 4'b1100, 32'h0, 32'hFFFF8001);
        tbl[6]  = mkv(1, 0, 2'd1, 0, 32'h00000302, 32'h0, 32'h1234F00D, 2, 0, 4'b0011, 32'h0, 32'h0000F00D);
        tbl[7]  = mkv(0, 1, 2'd0, 0, 32'h00000403, 32'h12345678, 32'h0, 1, 0, 4'b0001, 32'h78787878, 32'h0);
        tbl[8]  = mkv(1, 0, 2'd0, 1, 32'h00000007, 32'h0, 32'h000000FF, 4, 0, 4'b0001, 32'h0, 32'hFFFFFFFF);
        tbl[9]  = mkv(1, 0, 2'd1, 0, 32'h00000001, 32'h0, 32'h0, 1, 1, 4'b0000, 32'h0, 32'h0);
        tbl[10] = mkv(1, 0, 2'd3, 1, 32'h00000010, 32'h0, 32'h11223344, 2, 0, 4'b1111, 32'h0, 32'h11223344);
        tbl[11] = mkv(0, 1, 2'd2, 0, 32'h00000020, 32'hCAFEF00D, 32'h0, 1, 0, 4'b1111, 32'hCAFEF00D, 32'h0);
        tbl[12] = mkv(1, 1, 2'd0, 0, 32'h00000000, 32'h000000A5, 32'h0, 2, 0, 4'b1000, 32'hA5A5A5A5, 32'h0);

        rst = 1'b1; dram_ack = 1'b0; dram_rdata = '0; size = '0; is_signed = 1'b0;
        valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0; alu_result = '0; store_data = '0;
        last_alu = '0; last_dfm = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_state("rst0");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) apply(tbl[i]);

        // Stray ack while idle must not produce write-back
        dram_ack = 1'b1; dram_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        dram_ack = 1'b0;
        #1;
        chk("stray_wbv", 32'(wb_valid), 32'd0);
        chk("stray_req", 32'(dram_req), 32'd0);
        chk("stray_dfm", data_from_memory, last_dfm);

        // Ack never arrives: abort after TO busy cycles
        valid_in = 1'b1; is_load = 1'b1; is_store = 1'b0; size = 2'd2; alu_result = 32'h40;
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (dram_req && n < 64) begin
            n++;
            @(negedge clk);
        end
        #1;
        chk("timeout_req_cycles", 32'(n), 32'(TO));
        chk("timeout_berr", 32'(bus_error), 32'd1);
        chk("timeout_stall", 32'(stall), 32'd0);
        chk("timeout_wbv", 32'(wb_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("timeout_berr_fall", 32'(bus_error), 32'd0);

        for (int i = 0; i < 150; i++) begin
            int k;
            k = int'($urandom_range(0, 3));
            rv.ld = (k == 1) || (k == 3);
            rv.st = (k >= 2);
            rv.sz = 2'($urandom_range(0, 3));
            rv.sgn = 1'($urandom_range(0, 1));
            rv.addr = $urandom;
            rv.sd = $urandom;
            rv.rd = $urandom;
            rv.dly = int'($urandom_range(1, 5));
            apply(model(rv));
        end

        // Reset in the second busy cycle abandons the access
        valid_in = 1'b1; is_load = 1'b1; is_store = 1'b0; size = 2'd0; alu_result = 32'h101;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_state("rst_mid");
        rst = 1'b0;
        dram_ack = 1'b1; dram_rdata = 32'h12803456;
        @(negedge clk);
        dram_ack = 1'b0;
        #1;
        chk("late_ack_wbv", 32'(wb_valid), 32'd0);
        chk("late_ack_req", 32'(dram_req), 32'd0);
        last_alu = '0; last_dfm = '0;
        apply(mkv(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'h11223344, 2, 0, 4'b1111, 32'h0, 32'h11223344));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
